// File: rtl/sfr_pkg.sv
// sfr_pkg: shared types and default sizes for the special-function-register bank.
package sfr_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_NUM_REGS = 16;
    localparam int DEF_ADDR_W   = 4;

    // Bit-write sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RMW_RD = 2'd1,
        ST_RMW_WR = 2'd2
    } sfr_state_t;

    // CPU access type: {bit access, write}
    typedef enum logic [1:0] {
        ACC_BYTE_RD = 2'b00,
        ACC_BYTE_WR = 2'b01,
        ACC_BIT_RD  = 2'b10,
        ACC_BIT_WR  = 2'b11
    } sfr_access_t;

    function automatic sfr_access_t access_type(input logic is_bit, input logic is_wr);
        return sfr_access_t'({is_bit, is_wr});
    endfunction

endpackage

// File: rtl/sfr_cell.sv
// sfr_cell: one register with reset value, CPU > hardware > hold priority,
// and an optional forced value on bit 0 (used for the parity bit).
module sfr_cell
    import sfr_pkg::*;
#(
    parameter int                 DATA_W  = DEF_DATA_W,
    parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cpu_we,
    input  logic [DATA_W-1:0] i_cpu_data,
    input  logic              i_hw_we,
    input  logic [DATA_W-1:0] i_hw_data,
    input  logic              i_par_en,
    input  logic              i_par_bit,
    output logic [DATA_W-1:0] o_q,
    output logic [DATA_W-1:0] o_nxt
);

    logic [DATA_W-1:0] q_r;
    logic [DATA_W-1:0] nxt;

    // Next value: CPU write wins over hardware write, otherwise hold; bit 0 may be forced
    always_comb begin
        nxt = q_r;
        if (i_cpu_we) begin
            nxt = i_cpu_data;
        end else if (i_hw_we) begin
            nxt = i_hw_data;
        end
        if (i_par_en) begin
            nxt[0] = i_par_bit;
        end
    end

    // Register storage with synchronous active-low reset to its reset image
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            q_r <= RST_VAL;
        end else begin
            q_r <= nxt;
        end
    end

    assign o_q   = q_r;
    assign o_nxt = nxt;

endmodule

// File: rtl/sfr_bank.sv
// sfr_bank: generic array of NUM_REGS special-function registers with CPU
// byte/bit access (bit writes via a read-modify-write sequence), per-register
// hardware write strobes and a flat export of all registers.
// Optional feature macro SFR_PARITY_EN: PSW bit 0 tracks the XOR of the ACC register.
module sfr_bank
    import sfr_pkg::*;
#(
    parameter int                           DATA_W    = DEF_DATA_W,
    parameter int                           NUM_REGS  = DEF_NUM_REGS,
    parameter int                           ADDR_W    = DEF_ADDR_W,
    parameter logic [NUM_REGS*DATA_W-1:0]   RST_VALUE = '0,
    parameter int                           ACC_IDX   = 0,
    parameter int                           PSW_IDX   = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_req,
    input  logic                         i_we,
    input  logic                         i_bit,
    input  logic [ADDR_W-1:0]            i_addr,
    input  logic [$clog2(DATA_W)-1:0]    i_bit_sel,
    input  logic [DATA_W-1:0]            i_wdata,
    input  logic [NUM_REGS-1:0]          i_hw_we,
    input  logic [NUM_REGS*DATA_W-1:0]   i_hw_data,
    output logic                         o_ack,
    output logic                         o_busy,
    output logic [DATA_W-1:0]            o_rdata,
    output logic [NUM_REGS*DATA_W-1:0]   o_regs
);

    localparam int BIT_W = $clog2(DATA_W);

`ifdef SFR_PARITY_EN
    localparam bit PARITY_ON = 1'b1;
`else
    localparam bit PARITY_ON = 1'b0;
`endif

    sfr_state_t        state_q;
    sfr_state_t        state_d;
    sfr_access_t       acc;
    logic              accept;

    logic [ADDR_W-1:0] seq_idx_q;
    logic [BIT_W-1:0]  seq_bit_q;
    logic              seq_val_q;
    logic [DATA_W-1:0] temp_q;

    logic              ack_q;
    logic [DATA_W-1:0] rdata_q;

    logic [DATA_W-1:0] reg_q   [NUM_REGS];
    logic [DATA_W-1:0] reg_nxt [NUM_REGS];
    logic [NUM_REGS-1:0] cpu_we;
    logic [DATA_W-1:0] cpu_data [NUM_REGS];

    logic [DATA_W-1:0] rd_byte;
    logic [DATA_W-1:0] seq_nxt;
    logic              par_bit;

    function automatic logic [DATA_W-1:0] set_bit(input logic [DATA_W-1:0] v,
                                                  input logic [BIT_W-1:0]  sel,
                                                  input logic              b);
        logic [DATA_W-1:0] r;
        r      = v;
        r[sel] = b;
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] rd_format(input logic [DATA_W-1:0] v,
                                                    input logic              is_bit,
                                                    input logic [BIT_W-1:0]  sel);
        logic [DATA_W-1:0] r;
        r = v;
        if (is_bit) begin
            r    = '0;
            r[0] = v[sel];
        end
        return r;
    endfunction

    assign acc     = access_type(i_bit, i_we);
    assign accept  = (state_q == ST_IDLE) && i_req;
    assign par_bit = ^reg_q[ACC_IDX];

    // Next-state logic for the bit-write sequencer
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept && acc == ACC_BIT_WR) state_d = ST_RMW_RD;
            ST_RMW_RD: state_d = ST_RMW_WR;
            ST_RMW_WR: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Sequencer state register; reset aborts any sequence in flight
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Address decode for the CPU read mux and the sequencer's read capture;
    // unmatched (out-of-range) indices yield zero
    always_comb begin
        rd_byte = '0;
        seq_nxt = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (i_addr == ADDR_W'(k))    rd_byte = reg_q[k];
            if (seq_idx_q == ADDR_W'(k)) seq_nxt = reg_nxt[k];
        end
    end

    // Sequence context: latched at accept, temp captures the register's
    // post-edge value (hardware update included) while in RMW_RD
    always_ff @(posedge i_clk) begin
        if (accept && acc == ACC_BIT_WR) begin
            seq_idx_q <= i_addr;
            seq_bit_q <= i_bit_sel;
            seq_val_q <= i_wdata[0];
        end
        if (state_q == ST_RMW_RD) begin
            temp_q <= seq_nxt;
        end
    end

    // CPU write strobes: byte write at accept, or the merged value in RMW_WR
    // (a same-cycle hardware update replaces temp, only the target bit is forced)
    always_comb begin
        for (int k = 0; k < NUM_REGS; k++) begin
            cpu_we[k]   = 1'b0;
            cpu_data[k] = '0;
            if (accept && acc == ACC_BYTE_WR && i_addr == ADDR_W'(k)) begin
                cpu_we[k]   = 1'b1;
                cpu_data[k] = i_wdata;
            end else if (state_q == ST_RMW_WR && seq_idx_q == ADDR_W'(k)) begin
                cpu_we[k]   = 1'b1;
                cpu_data[k] = set_bit(i_hw_we[k] ? i_hw_data[k*DATA_W +: DATA_W] : temp_q,
                                      seq_bit_q, seq_val_q);
            end
        end
    end

    // Completion pulse and read data register; read data holds until the next read
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q <= (accept && acc != ACC_BIT_WR) || (state_q == ST_RMW_WR);
            if (accept && !i_we) begin
                rdata_q <= rd_format(rd_byte, i_bit, i_bit_sel);
            end
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_cell
        sfr_cell #(
            .DATA_W  (DATA_W),
            .RST_VAL (RST_VALUE[k*DATA_W +: DATA_W])
        ) u_cell (
            .i_clk      (i_clk),
            .i_rst      (i_rst),
            .i_cpu_we   (cpu_we[k]),
            .i_cpu_data (cpu_data[k]),
            .i_hw_we    (i_hw_we[k]),
            .i_hw_data  (i_hw_data[k*DATA_W +: DATA_W]),
            .i_par_en   (PARITY_ON && (k == PSW_IDX)),
            .i_par_bit  (par_bit),
            .o_q        (reg_q[k]),
            .o_nxt      (reg_nxt[k])
        );
        assign o_regs[k*DATA_W +: DATA_W] = reg_q[k];
    end

    assign o_ack   = ack_q;
    assign o_busy  = (state_q != ST_IDLE);
    assign o_rdata = rdata_q;

endmodule

// File: doc/sfr_bank.md
Name: sfr_bank

Overview:
- Parametrised special-function-register bank that replaces the fixed per-register instances with one generic array of NUM_REGS registers, each DATA_W bits wide.
- Sits between the CPU datapath and the peripherals (timers, UART, display, keypad). The CPU side gets address-decoded byte read/write and bit-addressable read/write (bit writes use a sequenced read-modify-write).
- Peripherals update registers through per-register hardware write strobes.
- The whole array is exported flat for direct peripheral use.

Parameters:
- DATA_W, 8, register width in bits.
- NUM_REGS, 16, number of registers, 1..2**ADDR_W.
- ADDR_W, 4, CPU register address width.
- RST_VALUE, all zeros ({NUM_REGS*DATA_W}), packed reset image; register k occupies bits [k*DATA_W +: DATA_W].
- ACC_IDX, 0, index of the accumulator register (used by the optional feature).
- PSW_IDX, 1, index of the status register (used by the optional feature).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; synchronous, active-low.
- i_req  in  1  CPU access request, sampled only while o_busy=0.
- i_we  in  1  1=write, 0=read.
- i_bit  in  1  1=bit access, 0=byte access.
- i_addr  in  ADDR_W  register index.
- i_bit_sel  in  $clog2(DATA_W)  bit index for bit access.
- i_wdata  in  DATA_W  write data; bit writes use i_wdata[0].
- i_hw_we  in  NUM_REGS  per-register hardware write strobe.
- i_hw_data  in  NUM_REGS*DATA_W  hardware write data, same packing as RST_VALUE.
- o_ack  out  1  single-cycle completion pulse.
- o_busy  out  1  high while a bit-write sequence is in progress.
- o_rdata  out  DATA_W  read data, valid while o_ack=1 and held until the next read completes.
- o_regs  out  NUM_REGS*DATA_W  current contents of all registers.

Behaviour:
- Reset (i_rst=0 at a clock edge):
  - registers load RST_VALUE;
  - FSM goes to IDLE;
  - o_ack=0, o_busy=0, o_rdata=0;
  - a sequence in progress is aborted with no write and no ack.
- FSM states: IDLE, RMW_RD, RMW_WR.
  - o_busy=1 in RMW_RD and RMW_WR.
  - i_req while busy is ignored: no ack, no effect.
- Byte write (IDLE):
  - the register is written at the accept edge;
  - o_ack=1 in the next cycle;
  - FSM stays IDLE, so back-to-back requests are allowed every cycle.
- Byte read: o_rdata is registered from register[i_addr] at the accept edge; o_ack=1 the next cycle (latency 1).
- Bit read: o_rdata = {zeros, register[i_addr][i_bit_sel]}, same latency 1.
- Bit write:
  - accept edge: IDLE -> RMW_RD; address, bit index and value are latched.
  - RMW_RD: temp <= register value, including any hardware update taken at that edge.
  - RMW_WR: writes (i_hw_we[idx] ? hw_data : temp) with only the selected bit replaced, then -> IDLE with o_ack=1.
  - Ack arrives 3 cycles after accept.
  - Hardware updates made during the sequence are preserved except for the target bit.
- Write priority within a cycle on the same register: CPU write (byte, or RMW_WR) > hardware write > hold.
- Out-of-range index (i_addr >= NUM_REGS): writes are dropped, reads return 0, and the access is still acked with normal latency.
- o_regs reflects register state after each edge (no extra latency).

Optional Feature:
- Macro: SFR_PARITY_EN.
- Defined:
  - register[PSW_IDX][0] equals the XOR-reduction of register[ACC_IDX] every cycle after reset;
  - CPU or hardware writes to that bit are overridden;
  - parity follows the ACC value one cycle after the ACC changes.
- Undefined: PSW bit 0 is ordinary storage.

Decomposition:
- Package sfr_pkg holds:
  - the FSM state enum;
  - access-type encoding (byte/bit, read/write);
  - default width constants.
- One sub-module, sfr_cell: a single register with reset value and the CPU/hardware/hold priority mux. sfr_bank instantiates NUM_REGS of them and holds the FSM and read path.

Test Plan:
1. Reset with RST_VALUE reg2=0x07: hold i_rst=0 for 2 cycles -> o_regs reg2=0x07, others 0x00; o_ack=0, o_rdata=0x00, o_busy=0.
2. Byte write 0xA5 to addr 3, then a byte read of addr 3 on the next cycle -> ack 1 cycle after each accept; o_rdata=0xA5.
3. Bit write: reg5=0x01, write bit 4 to 1, with i_hw_we[5] and data 0x81 during RMW_RD -> o_busy high 2 cycles, ack 3 cycles after accept, reg5=0x91. Repeating with i_rst=0 during RMW_WR -> reg5 equals reset value and no ack.
4. Same cycle: byte write 0x55 and hardware write 0xAA to reg 4 -> reg4=0x55. Hardware write alone -> reg4=0xAA.
5. NUM_REGS=12, write 0x33 to addr 15, then read addr 15 -> both acked; o_rdata=0x00; o_regs unchanged.
6. SFR_PARITY_EN defined: write ACC=0x07 -> PSW[0]=1 the next cycle; write PSW=0x00 -> PSW reads 0x01. Without the macro -> PSW reads 0x00.
